// File: rtl/apb_master_bridge_if.sv
// Bundle of processor-side request/response signals and APB bus signals
// seen by apb_master_bridge. The master modport is the bridge's view; the
// slave modport is the view of whatever sits around it (processor + slaves).
interface apb_master_bridge_if;
  // processor side
  logic       pm_start;
  logic       pm_write;
  logic [1:0] pm_sel;
  logic [7:0] pm_addr;
  logic [7:0] pm_wdata;
  logic [7:0] pm_wait;
  logic [7:0] pm_rdata;
  logic       pm_stable;
  logic       pm_error;
  // APB side
  logic [1:0] apb_sel;
  logic       apb_enable;
  logic       apb_write;
  logic [7:0] apb_addr;
  logic [7:0] apb_wdata;
  logic [7:0] apb_wait;
  logic       ready1;
  logic [7:0] rdata1;
  logic       ready2;
  logic [7:0] rdata2;

  modport master (
    input  pm_start, pm_write, pm_sel, pm_addr, pm_wdata, pm_wait,
    output pm_rdata, pm_stable, pm_error,
    output apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait,
    input  ready1, rdata1, ready2, rdata2
  );

  modport slave (
    output pm_start, pm_write, pm_sel, pm_addr, pm_wdata, pm_wait,
    input  pm_rdata, pm_stable, pm_error,
    input  apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait,
    output ready1, rdata1, ready2, rdata2
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Processor-request to APB bridge. One request at a time runs through
// SETUP/ACCESS on the shared APB bus; completion, read data and errors
// (unmapped slave ID, ACCESS timeout) are returned as a one-cycle pulse.
// Every output is a register; the APB output registers double as the
// request latch for the duration of a transfer.
module apb_master_bridge #(
  parameter logic [1:0]  SLV1_ID = 2'd1,
  parameter logic [1:0]  SLV2_ID = 2'd2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  apb_master_bridge_if.master bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          en_q, en_d;
  logic          wr_q, wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    wait_q, wait_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          stable_q, stable_d;
  logic          err_q, err_d;

  logic          rdy_mux;
  logic [7:0]    rdat_mux;
  logic          req_mapped;

  // ready/rdata come only from the slave named by the latched ID
  always_comb begin
    rdy_mux  = 1'b0;
    rdat_mux = 8'h00;
    if (sel_q == SLV1_ID) begin
      rdy_mux  = bus.ready1;
      rdat_mux = bus.rdata1;
    end else if (sel_q == SLV2_ID) begin
      rdy_mux  = bus.ready2;
      rdat_mux = bus.rdata2;
    end
  end

  assign req_mapped = (bus.pm_sel == SLV1_ID) || (bus.pm_sel == SLV2_ID);

  // next state and next registered outputs; pulses default low
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    en_d     = en_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    rdata_d  = rdata_q;
    stable_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pm_start) begin
          if (req_mapped) begin
            // loading the APB registers here makes SETUP visible one cycle after the start edge
            state_d = SETUP;
            sel_d   = bus.pm_sel;
            wr_d    = bus.pm_write;
            addr_d  = bus.pm_addr;
            wdata_d = bus.pm_wdata;
            wait_d  = bus.pm_wait;
          end else begin
            // unmapped ID: answer immediately, the bus never moves
            stable_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = 8'hFF;
          end
        end
      end
      SETUP: begin
        en_d    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (rdy_mux || (cnt_q == CNT_LAST)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          sel_d    = 2'd0;
          en_d     = 1'b0;
          wr_d     = 1'b0;
          addr_d   = 8'h00;
          wdata_d  = 8'h00;
          wait_d   = 8'h00;
          stable_d = 1'b1;
          if (rdy_mux) begin
            if (!wr_q) rdata_d = rdat_mux;
          end else begin
            // TIMEOUT-th ACCESS cycle without ready: abort
            err_d   = 1'b1;
            rdata_d = 8'hFF;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset drops any transfer silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      wait_q   <= 8'h00;
      rdata_q  <= 8'h00;
      stable_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      stable_q <= stable_d;
      err_q    <= err_d;
    end
  end

  assign bus.apb_sel    = sel_q;
  assign bus.apb_enable = en_q;
  assign bus.apb_write  = wr_q;
  assign bus.apb_addr   = addr_q;
  assign bus.apb_wdata  = wdata_q;
  assign bus.apb_wait   = wait_q;
  assign bus.pm_rdata   = rdata_q;
  assign bus.pm_stable  = stable_q;
  assign bus.pm_error   = err_q;
endmodule
